// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 4-bit ALU.
// Round-robin grant, registered operand latch, per-port result registers,
// one-cycle ack pulse and a wrapping completed-operation counter.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [2:0] sel0,
    output logic       ack0,
    output logic [3:0] res0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [2:0] sel1,
    output logic       ack1,
    output logic [3:0] res1,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_out,
    output logic       busy,
    output logic       gnt_id,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       gnt_id_q, gnt_id_d;
    logic       last_q, last_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [2:0] alu_sel_q, alu_sel_d;
    logic [3:0] res0_q, res0_d;
    logic [3:0] res1_q, res1_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       busy_q, busy_d;
    logic [7:0] op_count_q, op_count_d;

    // Round-robin pick: on contention the port not served last wins;
    // a lone request wins outright.
    function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
        logic pick;
        if (r0 && r1) begin
            pick = ~last;
        end else if (r0) begin
            pick = 1'b0;
        end else begin
            pick = 1'b1;
        end
        return pick;
    endfunction

    // Next-state and next-output logic for the IDLE/EXEC/DONE sequence.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        last_d     = last_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        res0_d     = res0_q;
        res1_d     = res1_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d  = EXEC;
                    gnt_id_d = rr_pick(req0, req1, last_q);
                    if (gnt_id_d) begin
                        alu_a_d   = a1;
                        alu_b_d   = b1;
                        alu_sel_d = sel1;
                    end else begin
                        alu_a_d   = a0;
                        alu_b_d   = b0;
                        alu_sel_d = sel0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // The ALU has had a full cycle on the latched operands.
                state_d = DONE;
                if (gnt_id_q) begin
                    res1_d = alu_out;
                    ack1_d = 1'b1;
                end else begin
                    res0_d = alu_out;
                    ack0_d = 1'b1;
                end
            end
            DONE: begin
                state_d    = IDLE;
                op_count_d = op_count_q + 8'd1;
                last_d     = gnt_id_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_id_q   <= 1'b0;
            last_q     <= 1'b1;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_sel_q  <= 3'd0;
            res0_q     <= 4'd0;
            res1_q     <= 4'd0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            op_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            last_q     <= last_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            res0_q     <= res0_d;
            res1_q     <= res1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
            op_count_q <= op_count_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign res0     = res0_q;
    assign res1     = res1_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign busy     = busy_q;
    assign gnt_id   = gnt_id_q;
    assign op_count = op_count_q;

endmodule
